// File: rtl/jtpopeye_dwnld_pkg.sv
// jtpopeye_dwnld_pkg: shared state encodings and address width for the download generator
package jtpopeye_dwnld_pkg;
  localparam int ADDR_W = 22;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_GAP   = 3'd3;
  localparam state_t ST_TAIL  = 3'd4;
endpackage

// File: rtl/jtpopeye_dwnld_pacer.sv
// jtpopeye_dwnld_pacer: loadable down-counter that parks at zero and flags it
module jtpopeye_dwnld_pacer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/jtpopeye_dwnld_gen.sv
// jtpopeye_dwnld_gen: byte stream to paced ioctl write strobes for ROM download.
// Define JTPOPEYE_DWNLD_CHKSUM_EN to add a 16-bit running checksum output.
module jtpopeye_dwnld_gen
  import jtpopeye_dwnld_pkg::*;
#(
  parameter int                WR_GAP   = 8,
  parameter int                TAIL     = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 22'h3FFFFF
) (
  input  logic              clk_rom,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  input  logic              src_last,
  output logic              src_ready,
  output logic              downloading,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_data,
  output logic              ioctl_wr,
  output logic              done,
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  output logic [15:0]       chksum,
`endif
  output logic              overflow
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              last_q, fin, gap_zero, tail_zero, at_max;
  assign src_ready = state == ST_WAIT;
  assign ioctl_wr  = state == ST_WRITE;
  assign at_max    = ioctl_addr == MAX_ADDR;
  jtpopeye_dwnld_pacer #(.W(8)) u_gap (
    .clk  (clk_rom),
    .rst_n(rst_n),
    .load (state == ST_WRITE),
    .en   (state == ST_GAP),
    .val  (8'(WR_GAP - 1)),
    .zero (gap_zero)
  );
  jtpopeye_dwnld_pacer #(.W(16)) u_tail (
    .clk  (clk_rom),
    .rst_n(rst_n),
    .load (state == ST_GAP && gap_zero && fin),
    .en   (state == ST_TAIL),
    .val  (16'(TAIL - 1)),
    .zero (tail_zero)
  );
  always_ff @(posedge clk_rom or negedge rst_n)
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr        <= '0;
      last_q      <= 1'b0;
      fin         <= 1'b0;
      downloading <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      ioctl_addr  <= '0;
      ioctl_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state       <= ST_WAIT;
          downloading <= 1'b1;
          addr        <= '0;
          overflow    <= 1'b0;
        end
        ST_WAIT: if (src_valid) begin
          state      <= ST_WRITE;
          ioctl_addr <= addr;
          ioctl_data <= src_data;
          last_q     <= src_last;
        end
        ST_WRITE: begin
          state <= ST_GAP;
          fin   <= last_q || at_max;
          if (!last_q && at_max) overflow <= 1'b1;
          if (!at_max) addr <= ioctl_addr + 1'b1;
        end
        ST_GAP: if (gap_zero) state <= fin ? ST_TAIL : ST_WAIT;
        ST_TAIL: if (tail_zero) begin
          state       <= ST_IDLE;
          downloading <= 1'b0;
          done        <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  always_ff @(posedge clk_rom or negedge rst_n)
    if (!rst_n) chksum <= '0;
    else if (state == ST_IDLE && start) chksum <= '0;
    else if (state == ST_WRITE) chksum <= chksum + {8'h00, ioctl_data};
`endif
endmodule

// File: tb/tb_jtpopeye_dwnld_gen.sv
// tb_jtpopeye_dwnld_gen: scoreboard bench for the download generator (default and small-MAX_ADDR instances)
module tb_jtpopeye_dwnld_gen;
  localparam int WR_GAP = 8;
  localparam int TAIL   = 16;

  logic        clk_rom = 0, rst_n = 0, start_a = 0, start_b = 0;
  logic        src_valid = 0, src_last = 0;
  logic [7:0]  src_data = 0;
  logic        ready_a, dl_a, wr_a, done_a, ov_a, ready_b, dl_b, wr_b, done_b, ov_b;
  logic [21:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  logic [15:0] ck_a, ck_b;
`endif

  jtpopeye_dwnld_gen #(.WR_GAP(WR_GAP), .TAIL(TAIL)) dut_a (
    .clk_rom(clk_rom), .rst_n(rst_n), .start(start_a), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(ready_a),
    .downloading(dl_a), .ioctl_addr(addr_a), .ioctl_data(data_a),
    .ioctl_wr(wr_a), .done(done_a),
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    .chksum(ck_a),
`endif
    .overflow(ov_a));

  jtpopeye_dwnld_gen #(.WR_GAP(WR_GAP), .TAIL(TAIL), .MAX_ADDR(22'h000003)) dut_b (
    .clk_rom(clk_rom), .rst_n(rst_n), .start(start_b), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(ready_b),
    .downloading(dl_b), .ioctl_addr(addr_b), .ioctl_data(data_b),
    .ioctl_wr(wr_b), .done(done_b),
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    .chksum(ck_b),
`endif
    .overflow(ov_b));

  always #5 clk_rom = ~clk_rom;

  typedef struct {logic [7:0] d; logic last; logic [21:0] addr;} vec_t;
  typedef struct {logic [21:0] a; logic [7:0] d;} exp_t;
  vec_t tbl[4];
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0, last_wr = 0, n_done_a = 0;
  bit sel = 0, strict = 1, have_prev = 0;

  logic        ready_m, dl_m, wr_m, done_m, ov_m;
  logic [21:0] addr_m;
  logic [7:0]  data_m;
  assign ready_m = sel ? ready_b : ready_a;
  assign dl_m    = sel ? dl_b : dl_a;
  assign wr_m    = sel ? wr_b : wr_a;
  assign done_m  = sel ? done_b : done_a;
  assign ov_m    = sel ? ov_b : ov_a;
  assign addr_m  = sel ? addr_b : addr_a;
  assign data_m  = sel ? data_b : data_a;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk_rom) cyc <= cyc + 1;
  always @(negedge clk_rom) if (done_a) n_done_a++;

  always @(negedge clk_rom) if (rst_n) begin
    if (wr_m) begin
      chk("wr_has_xfer", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", addr_m, e.a);
        chk("wr_data", data_m, e.d);
      end
      if (have_prev)
        chk("wr_spacing", (strict || cyc - last_wr < WR_GAP + 2) ? cyc - last_wr : WR_GAP + 2, WR_GAP + 2);
      have_prev = 1;
      last_wr   = cyc;
    end else if (have_prev && cyc - last_wr >= 1 && cyc - last_wr <= WR_GAP)
      chk("ready_in_gap", ready_m, 0);
  end

  task automatic send(input logic [7:0] d, input bit last, input logic [21:0] ea, input bit rnd);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (!ok && n < 600) begin
      @(negedge clk_rom);
      n++;
      src_data  = d;
      src_last  = last;
      src_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_valid && ready_m) begin
        sb.push_back('{a: ea, d: d});
        ok = 1;
      end
    end
    chk("send_accepted", ok, 1);
  endtask

  task automatic idle();
    @(negedge clk_rom);
    src_valid = 0;
    src_last  = 0;
  endtask

  task automatic do_start();
    @(negedge clk_rom);
    if (sel) start_b = 1; else start_a = 1;
    have_prev = 0;
    @(negedge clk_rom);
    start_a = 0;
    start_b = 0;
    chk("dl_after_start", dl_m, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_m && n < 3000) begin
      @(negedge clk_rom);
      n++;
    end
    chk("done_seen", done_m, 1);
    chk("done_delay", cyc - last_wr, TAIL + WR_GAP + 1);
    chk("dl_at_done", dl_m, 0);
    chk("sb_drained", sb.size(), 0);
    @(negedge clk_rom);
    chk("done_pulse", done_m, 0);
  endtask

  task automatic run_table();
    do_start();
    for (int i = 0; i < 4; i++) send(tbl[i].d, tbl[i].last, tbl[i].addr, 0);
    idle();
    wait_done();
    chk("no_ovf_table", ov_m, 0);
  endtask

  initial begin
    tbl[0] = '{8'h11, 1'b0, 22'd0};
    tbl[1] = '{8'h22, 1'b0, 22'd1};
    tbl[2] = '{8'h33, 1'b0, 22'd2};
    tbl[3] = '{8'h44, 1'b1, 22'd3};
    repeat (3) @(negedge clk_rom);
    chk("rst_a", {ready_a, dl_a, addr_a, data_a, wr_a, done_a, ov_a}, 0);
    chk("rst_b", {ready_b, dl_b, addr_b, data_b, wr_b, done_b, ov_b}, 0);
    rst_n = 1;

    sel = 0;
    strict = 1;
    run_table();

    strict = 0;
    do_start();
    for (int i = 0; i < 12; i++) send(8'($urandom), i == 11, 22'(i), 1);
    idle();
    wait_done();
    strict = 1;

    do_start();
    send(8'hA0, 0, 22'd0, 0);
    send(8'hA1, 0, 22'd1, 0);
    @(negedge clk_rom) start_a = 1;
    @(negedge clk_rom) start_a = 0;
    send(8'hA2, 0, 22'd2, 0);
    send(8'hA3, 1, 22'd3, 0);
    idle();
    wait_done();
    do_start();
    send(8'h5A, 1, 22'd0, 0);
    idle();
    wait_done();

    sel = 1;
    do_start();
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 0, 22'(i), 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_rom);
      src_valid = 1;
      src_data  = 8'h3F;
      chk("ready_after_max", ready_b, 0);
    end
    idle();
    wait_done();
    chk("overflow_set", ov_b, 1);
    do_start();
    chk("overflow_cleared", ov_b, 0);
    for (int i = 0; i < 4; i++) send(8'h70 + 8'(i), i == 3, 22'(i), 0);
    idle();
    wait_done();
    chk("last_wins_over_max", ov_b, 0);

    sel = 0;
    do_start();
    send(8'hC0, 0, 22'd0, 0);
    send(8'hC1, 0, 22'd1, 0);
    begin
      int n, snap;
      n = 0;
      while (!(wr_a && addr_a == 22'd1) && n < 60) begin
        @(negedge clk_rom);
        n++;
      end
      chk("byte2_written", wr_a, 1);
      repeat (3) @(negedge clk_rom);
      src_valid = 0;
      snap = n_done_a;
      #2 rst_n = 0;
      #1 chk("async_rst_a", {ready_a, dl_a, addr_a, data_a, wr_a, done_a, ov_a}, 0);
      repeat (3) @(negedge clk_rom);
      chk("no_done_on_rst", n_done_a, snap);
      rst_n = 1;
    end
    sb.delete();
    run_table();

`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    do_start();
    for (int i = 0; i < 300; i++) send(8'hFF, i == 299, 22'(i), 0);
    idle();
    wait_done();
    chk("chksum", ck_a, 16'h2AD4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
